sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port request arbiter directly upstream of `sram_ctl`. It accepts instruction-fetch reads and data-port reads and writes from the CPU and serialises them into `sram_ctl`'s start/rw/addr/data/be handshake. It waits for `r_ready`/`w_finish` and returns the result to the winning port with a one-cycle acknowledge. A watchdog converts a hung SRAM transaction into an error response.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles allowed in WAIT before an error acknowledge.
- `ADDR_W`, default 24: width of the word address driven to `sram_ctl`.

Ports (the CPU side uses byte addresses):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `if_req_i` in 1: instruction read request, held until `if_ack_o`.
- `if_addr_i` in 32: instruction byte address.
- `if_rdata_o` out 32: instruction read data, valid with `if_ack_o`.
- `if_ack_o` out 1: one-cycle completion pulse.
- `if_err_o` out 1: timeout flag, valid with `if_ack_o`.
- `d_req_i` in 1: data request, held until `d_ack_o`.
- `d_we_i` in 1: 1 selects write, 0 selects read.
- `d_addr_i` in 32: data byte address.
- `d_wdata_i` in 32: write data.
- `d_wstrb_i` in 4: byte enables, active-high.
- `d_rdata_o` out 32: read data, valid with `d_ack_o`.
- `d_ack_o` out 1: one-cycle completion pulse.
- `d_err_o` out 1: timeout flag, valid with `d_ack_o`.
- `sram_start_o` out 1: one-cycle start pulse to `sram_ctl`.
- `sram_rw_o` out 1: 1 selects read, 0 selects write (`sram_ctl` encoding).
- `sram_addr_o` out ADDR_W: word address, equal to byte address bits [ADDR_W+1:2].
- `sram_data_o` out 32: write data.
- `sram_be_n_o` out 4: active-low byte enables, equal to `~wstrb`; all zeros for reads.
- `sram_data_i` in 32: read data from `sram_ctl`.
- `sram_r_ready_i` in 1: read data valid.
- `sram_w_finish_i` in 1: write complete.
- `sram_busy_i` in 1: `sram_ctl` is occupied.

## Operation

States:
- **IDLE**:
  - Sample the requests.
  - If at least one request is pending and `sram_busy_i`=0, grant one port and latch its addr/wdata/be/rw into command registers.
  - Go to ISSUE.
- **ISSUE**:
  - Assert `sram_start_o` for exactly one cycle with the latched command on the sram_* outputs.
  - Clear the watchdog.
  - Go to WAIT.
- **WAIT**:
  - Hold the sram_* outputs stable.
  - On `sram_r_ready_i` (read) or `sram_w_finish_i` (write), register `sram_data_i` into the granted port's rdata and go to RESP.
  - If the watchdog reaches TIMEOUT_CYCLES-1 first, set the error flag and go to RESP; rdata is 0 in this case.
- **RESP**:
  - Pulse the granted port's ack (and err if set) for one cycle.
  - Update the round-robin pointer.
  - Return to IDLE.

Arbitration:
- If both ports request in the same IDLE cycle, grant the port that was not granted last.
- The pointer resets to favour the data port.
- Only one request is ever outstanding.

Zero-strobe write (`d_we_i`=1, `d_wstrb_i`=0):
- Go IDLE→RESP directly, with no `sram_start_o`.
- `d_ack_o` pulses the cycle after the grant.

Requester rules:
- A port must keep req and its payload stable until ack.
- Deasserting req before ack is illegal; the arbiter still completes the transaction and pulses ack.
- A port may reassert req in the cycle after ack; it is then considered in the next IDLE cycle.

## Timing

Reset values:
- All outputs 0, except `sram_be_n_o`=4'hF and `sram_rw_o`=1.
- State is IDLE, the watchdog is 0, and the round-robin pointer favours data.

Reset during any state:
- The next cycle is IDLE with reset output values.
- No ack is produced for the aborted transaction.
- `sram_ctl` shares `rst_i`.

Latency:
- Request seen in IDLE at cycle 0.
- `sram_start_o` at cycle 1.
- The completion strobe arrives at cycle 1+k.
- Ack at cycle 2+k.
- Total: 2 cycles of arbitration overhead plus the `sram_ctl` latency k.

Other rules:
- If `sram_busy_i`=1 in IDLE, grant nothing; requests wait.
- If a completion strobe and the watchdog expiry coincide, the completion wins and err=0.
- The watchdog is a $clog2(TIMEOUT_CYCLES)-bit counter that saturates and never wraps.
- Back-to-back throughput: one transaction per k+3 cycles.

## Structure

- State encodings, the `RW_READ`/`RW_WRITE` constants and the TIMEOUT default go in `common.vh` as shared defines.
- One sub-module: `rr_arb2`, a two-requestor round-robin picker.
  - Inputs: `req[1:0]`, `update`.
  - Output: one-hot `gnt[1:0]`.
  - Holds the pointer register.
- The FSM, command registers and watchdog stay in `sram_arbiter`.

## Test plan

- Single fetch: `if_addr_i`=0x0000_0010 with the SRAM model holding 0xDEADBEEF at word 4 → `sram_addr_o`=4, `sram_rw_o`=1, `sram_be_n_o`=0; `if_rdata_o`=0xDEADBEEF with a one-cycle `if_ack_o`, `if_err_o`=0.
- Byte write: `d_addr_i`=0x20, `d_wdata_i`=0x11223344, `d_wstrb_i`=4'b0010 → `sram_be_n_o`=4'b1101, `sram_rw_o`=0, exactly one `sram_start_o`; a follow-up read of word 8 shows byte 1=0x33 with the other bytes unchanged.
- Contention: both ports request continuously for 4 transactions → grants alternate D,I,D,I, and no port is acknowledged twice in a row.
- Busy hold-off: `sram_busy_i`=1 for 5 cycles while `d_req_i`=1 → no `sram_start_o` during those cycles; start appears 1 cycle after busy drops.
- Timeout: the model never returns ready on a read, TIMEOUT_CYCLES=8 → ack+err exactly once with rdata=0, then the FSM is back in IDLE.
- Reset in WAIT and zero-strobe write: assert `rst_i` mid-WAIT → no ack and all outputs at reset values. After that, a write with `d_wstrb_i`=0 → `d_ack_o` 1 cycle after the grant with no `sram_start_o`.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM request arbiter.
// Imported by the arbiter top and its round-robin picker.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int TIMEOUT_DEF = 64;

  localparam int PORT_D = 0;
  localparam int PORT_I = 1;

  // sram_ctl wants active-low enables, all enabled on reads
  function automatic logic [3:0] be_n_of(
    input logic       we,
    input logic [3:0] strb
  );
    return we ? ~strb : 4'h0;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-requestor round-robin picker; bit 0 is the data port.
// The pointer moves to favour the loser whenever update_i is high.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (update_i) begin
      prio_d = gnt_o[PORT_D];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises fetch and data requests into the sram_ctl handshake,
// with round-robin arbitration and a watchdog on hung transactions.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int ADDR_W         = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ack_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wstrb_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic              sram_start_o,
  output logic              sram_rw_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  output logic [3:0]        sram_be_n_o,
  input  logic [31:0]       sram_data_i,
  input  logic              sram_r_ready_i,
  input  logic              sram_w_finish_i,
  input  logic              sram_busy_i
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX = '1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              rw_q, rw_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic [1:0] arb_req, arb_gnt;
  logic       arb_upd;
  logic       done;
  logic       zero_wr;
  logic       unused_addr;

  assign unused_addr = ^{if_addr_i, d_addr_i};

  // In RESP the picker sees only the owner, so update favours the other port
  assign arb_req = (state_q == ST_RESP) ?
                   {owner_q, ~owner_q} : {if_req_i, d_req_i};
  assign arb_upd = (state_q == ST_RESP);

  rr_arb2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (arb_req),
    .update_i (arb_upd),
    .gnt_o    (arb_gnt)
  );

  assign zero_wr = d_we_i && (d_wstrb_i == 4'h0);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_n_d     = be_n_q;
    rw_d       = rw_q;
    wd_d       = wd_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sram_busy_i && (|arb_gnt)) begin
          err_d = 1'b0;
          if (arb_gnt[PORT_I]) begin
            owner_d = 1'b1;
            addr_d  = if_addr_i[ADDR_W+1:2];
            wdata_d = '0;
            be_n_d  = 4'h0;
            rw_d    = RW_READ;
            state_d = ST_ISSUE;
          end else if (arb_gnt[PORT_D]) begin
            owner_d = 1'b0;
            addr_d  = d_addr_i[ADDR_W+1:2];
            wdata_d = d_we_i ? d_wdata_i : '0;
            be_n_d  = be_n_of(d_we_i, d_wstrb_i);
            rw_d    = d_we_i ? RW_WRITE : RW_READ;
            state_d = zero_wr ? ST_RESP : ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        done = (rw_q == RW_READ) ? sram_r_ready_i
                                 : sram_w_finish_i;
        // completion beats a coincident watchdog expiry
        if (done) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (owner_q) if_rdata_d = sram_data_i;
          else         d_rdata_d  = sram_data_i;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          if (owner_q) if_rdata_d = '0;
          else         d_rdata_d  = '0;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_n_q     <= 4'hF;
      rw_q       <= RW_READ;
      wd_q       <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_n_q     <= be_n_d;
      rw_q       <= rw_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign sram_start_o = (state_q == ST_ISSUE);
  assign sram_rw_o    = rw_q;
  assign sram_addr_o  = addr_q;
  assign sram_data_o  = wdata_q;
  assign sram_be_n_o  = be_n_q;

  assign if_ack_o   = (state_q == ST_RESP) && owner_q;
  assign d_ack_o    = (state_q == ST_RESP) && !owner_q;
  assign if_err_o   = if_ack_o && err_q;
  assign d_err_o    = d_ack_o && err_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter against a transaction-level
// timing model, plus directed scenarios with literal expectations.
module tb_sram_arbiter;

  localparam int T  = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          if_req_i, if_ack_o, if_err_o;
  logic [31:0]   if_addr_i, if_rdata_o;
  logic          d_req_i, d_we_i, d_ack_o, d_err_o;
  logic [31:0]   d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]    d_wstrb_i;
  logic          sram_start_o, sram_rw_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_data_o, sram_data_i;
  logic [3:0]    sram_be_n_o;
  logic          sram_r_ready_i, sram_w_finish_i;
  logic          sram_busy_i;

  sram_arbiter #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .sram_start_o(sram_start_o), .sram_rw_o(sram_rw_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_be_n_o(sram_be_n_o), .sram_data_i(sram_data_i),
    .sram_r_ready_i(sram_r_ready_i),
    .sram_w_finish_i(sram_w_finish_i),
    .sram_busy_i(sram_busy_i)
  );

  typedef struct packed {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          k;
    bit          hang;
    int          gap;
  } req_t;

  req_t dq[$], iq[$];
  req_t dcur, icur, ar;
  bit   dpend, ipend;
  int   dfree, ifree;
  logic [31:0] mem [0:255];

  int n_vec, n_bad, cyc;
  bit armed, act, aport, last_i, exp_err;
  int start_c, strobe_c, ack_c, idle_at, rst_chk;
  logic [31:0] exp_rd;
  int busy_left;

  int n_start, start_cyc_cap, ack_cyc_cap, req_cyc_cap;
  logic [AW-1:0] cap_addr;
  logic cap_rw, cap_err;
  logic [3:0] cap_be;
  logic [31:0] cap_rdata;
  bit ack_log[$];

  function automatic void chk(string nm, logic [31:0] a,
                              logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, a, e, cyc);
    end
  endfunction

  function automatic int idx(logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic void push(bit port_i, bit we,
      logic [31:0] a, logic [31:0] wd, logic [3:0] s,
      int k, bit hang, int gap);
    req_t r = '0;
    r.we = port_i ? 1'b0 : we;
    r.addr = a; r.wdata = wd; r.strb = s;
    r.k = k; r.hang = hang; r.gap = gap;
    if (port_i) iq.push_back(r);
    else        dq.push_back(r);
  endfunction

  task automatic step(input bit do_rst);
    int i;
    logic [3:0] ben;
    @(negedge clk);
    if (armed) begin
      if (cyc == rst_chk) begin
        chk("rst_start", sram_start_o, 0);
        chk("rst_rw", sram_rw_o, 1);
        chk("rst_be_n", sram_be_n_o, 4'hF);
        chk("rst_addr", sram_addr_o, 0);
        chk("rst_wdata", sram_data_o, 0);
        chk("rst_acks",
            {if_ack_o, if_err_o, d_ack_o, d_err_o}, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
      end else begin
        chk("start", sram_start_o, act && cyc == start_c);
        chk("if_ack", if_ack_o, act && aport && cyc == ack_c);
        chk("d_ack", d_ack_o, act && !aport && cyc == ack_c);
        chk("if_err", if_err_o,
            act && aport && cyc == ack_c && exp_err);
        chk("d_err", d_err_o,
            act && !aport && cyc == ack_c && exp_err);
        if (act && start_c >= 0 && cyc >= start_c &&
            cyc <= ack_c) begin
          ben = ar.we ? ~ar.strb : 4'h0;
          chk("sram_addr", sram_addr_o, ar.addr[AW+1:2]);
          chk("sram_rw", sram_rw_o, !ar.we);
          chk("sram_be_n", sram_be_n_o, ben);
          if (ar.we) chk("sram_wdata", sram_data_o, ar.wdata);
        end
        if (act && cyc == ack_c && (!ar.we || exp_err)) begin
          if (aport) chk("if_rdata", if_rdata_o, exp_rd);
          else       chk("d_rdata", d_rdata_o, exp_rd);
        end
      end
    end
    if (sram_start_o) begin
      n_start++;
      start_cyc_cap = cyc;
      cap_addr = sram_addr_o;
      cap_rw = sram_rw_o;
      cap_be = sram_be_n_o;
    end
    if (if_ack_o || d_ack_o) begin
      ack_cyc_cap = cyc;
      ack_log.push_back(if_ack_o);
      cap_rdata = if_ack_o ? if_rdata_o : d_rdata_o;
      cap_err = if_ack_o ? if_err_o : d_err_o;
    end
    if (act && cyc == ack_c) begin
      act = 1'b0;
      if (aport) begin ipend = 0; ifree = cyc + 1; end
      else       begin dpend = 0; dfree = cyc + 1; end
    end
    rst_i = do_rst;
    if (!dpend && dq.size() > 0 && cyc >= dfree + dq[0].gap) begin
      dcur = dq.pop_front(); dpend = 1; req_cyc_cap = cyc;
    end
    if (!ipend && iq.size() > 0 && cyc >= ifree + iq[0].gap) begin
      icur = iq.pop_front(); ipend = 1; req_cyc_cap = cyc;
    end
    d_req_i = dpend; d_we_i = dcur.we; d_addr_i = dcur.addr;
    d_wdata_i = dcur.wdata; d_wstrb_i = dcur.strb;
    if_req_i = ipend; if_addr_i = icur.addr;
    sram_busy_i = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    sram_r_ready_i = 1'b0;
    sram_w_finish_i = 1'b0;
    sram_data_i = $urandom;
    if (act && cyc == strobe_c) begin
      i = idx(ar.addr);
      if (ar.we) begin
        sram_w_finish_i = 1'b1;
        for (int b = 0; b < 4; b++)
          if (ar.strb[b]) mem[i][8*b +: 8] = ar.wdata[8*b +: 8];
      end else begin
        sram_r_ready_i = 1'b1;
        sram_data_i = mem[i];
      end
    end
    if (do_rst) begin
      act = 0; dpend = 0; ipend = 0;
      dfree = cyc + 1; ifree = cyc + 1;
      last_i = 1; idle_at = cyc + 1; rst_chk = cyc + 1;
      armed = 1;
    end else if (armed && cyc == idle_at) begin
      if (!sram_busy_i && (dpend || ipend)) begin
        aport = ipend && (!dpend || !last_i);
        last_i = aport;
        ar = aport ? icur : dcur;
        act = 1; exp_err = 0;
        exp_rd = mem[idx(ar.addr)];
        if (ar.we && ar.strb == 4'h0) begin
          start_c = -1; strobe_c = -1; ack_c = cyc + 1;
        end else begin
          start_c = cyc + 1;
          if (ar.hang) begin
            strobe_c = -1; ack_c = cyc + 2 + T;
            exp_err = 1; exp_rd = 0;
          end else begin
            strobe_c = cyc + 1 + ar.k; ack_c = cyc + 2 + ar.k;
          end
        end
        idle_at = ack_c + 1;
      end else begin
        idle_at = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic run_idle(input int max, input bit rbusy);
    int n = 0;
    do begin
      if (rbusy && busy_left == 0 && $urandom_range(0, 15) == 0)
        busy_left = $urandom_range(1, 4);
      step(0);
      n++;
    end while ((act || dpend || ipend || dq.size() > 0 ||
                iq.size() > 0) && n < max);
    if (act || dpend || ipend || dq.size() > 0 || iq.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL run_idle: still busy after %0d cycles", n);
    end
  endtask

  int s0, a0;
  bit [3:0] ord;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; armed = 0; act = 0;
    dpend = 0; ipend = 0; dfree = 0; ifree = 0; busy_left = 0;
    n_start = 0; rst_chk = -1; idle_at = -1; last_i = 1;
    dcur = '0; icur = '0; ar = '0;
    rst_i = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0;
    d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_wstrb_i = 0;
    sram_data_i = 0; sram_r_ready_i = 0; sram_w_finish_i = 0;
    sram_busy_i = 0;
    foreach (mem[i]) mem[i] = $urandom;
    step(1); step(1);

    mem[4] = 32'hDEADBEEF;
    a0 = ack_log.size();
    push(1, 0, 32'h10, 0, 0, 2, 0, 0);
    run_idle(100, 0);
    chk("fetch_addr", cap_addr, 4);
    chk("fetch_rw", cap_rw, 1);
    chk("fetch_be_n", cap_be, 0);
    chk("fetch_rdata", cap_rdata, 32'hDEADBEEF);
    chk("fetch_err", cap_err, 0);
    chk("fetch_latency", ack_cyc_cap - req_cyc_cap, 4);
    chk("fetch_ack_count", ack_log.size() - a0, 1);

    mem[8] = 32'hAABBCCDD;
    s0 = n_start;
    push(0, 1, 32'h20, 32'h11223344, 4'b0010, 3, 0, 0);
    run_idle(100, 0);
    chk("bw_be_n", cap_be, 4'b1101);
    chk("bw_rw", cap_rw, 0);
    chk("bw_starts", n_start - s0, 1);
    push(0, 0, 32'h20, 0, 0, 1, 0, 0);
    run_idle(100, 0);
    chk("bw_readback", cap_rdata, 32'hAABB33DD);

    step(1);
    ack_log.delete();
    for (int n = 0; n < 2; n++) begin
      push(0, 0, 32'h40 + n * 4, 0, 0, 1 + n, 0, 0);
      push(1, 0, 32'h80 + n * 4, 0, 0, 2 + n, 0, 0);
    end
    run_idle(200, 0);
    chk("contend_count", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      ord = {ack_log[3], ack_log[2], ack_log[1], ack_log[0]};
      chk("contend_order", ord, 4'b1010);
    end

    busy_left = 5;
    push(0, 0, 32'h44, 0, 0, 1, 0, 0);
    run_idle(100, 0);
    chk("busy_start_delay", start_cyc_cap - req_cyc_cap, 6);

    a0 = ack_log.size();
    push(1, 0, 32'h30, 0, 0, 1, 1, 0);
    run_idle(100, 0);
    chk("to_err", cap_err, 1);
    chk("to_rdata", cap_rdata, 0);
    chk("to_latency", ack_cyc_cap - start_cyc_cap, T + 1);
    chk("to_ack_count", ack_log.size() - a0, 1);
    push(1, 0, 32'h10, 0, 0, T, 0, 0);
    run_idle(100, 0);
    chk("tie_err", cap_err, 0);
    chk("tie_rdata", cap_rdata, 32'hDEADBEEF);

    a0 = ack_log.size();
    push(0, 0, 32'h50, 0, 0, 1, 1, 0);
    for (int n = 0; n < 4; n++) step(0);
    step(1);
    for (int n = 0; n < 15; n++) step(0);
    chk("rst_no_ack", ack_log.size() - a0, 0);

    s0 = n_start;
    push(0, 1, 32'h60, 32'hCAFEF00D, 4'h0, 1, 0, 0);
    run_idle(100, 0);
    chk("zs_latency", ack_cyc_cap - req_cyc_cap, 1);
    chk("zs_starts", n_start - s0, 0);

    for (int n = 0; n < 300; n++) begin
      push($urandom_range(0, 1), $urandom_range(0, 1),
           $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(1, T), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3));
    end
    run_idle(20000, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
